// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Shares the two register-file writeback ports between the two in-order pipe
// lanes and three long-latency units (mul=0, div=1, lsu=2).
//   - Lane N owns writeback port N whenever pipeN_valid_i is high. Its payload
//     and redirect request pass straight through.
//   - Idle ports are handed to the units round-robin through valid/ready.
//     The search starts at rr_ptr and wraps modulo 3. The first requester takes
//     the lowest free port and the second takes the other free port.
//   - Each unit has a saturating wait counter. When any counter reaches
//     STARVE_LIMIT, stall_issue_o is raised so that the lanes drain and free
//     the ports.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   pipeN_* (N=0,1)            lane result and redirect, no backpressure
//   umul_*, udiv_*, ulsu_*     unit result (valid/payload in, ready out)
//   wbP_* (P=0,1)              writeback port P
//   stall_issue_o              registered issue stall
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int SID_W        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             pipe0_valid_i,
  input  logic [4:0]       pipe0_rd_i,
  input  logic [63:0]      pipe0_value_i,
  input  logic [31:0]      pipe0_inst_i,
  input  logic [SID_W-1:0] pipe0_sid_i,
  input  logic             pipe0_redirect_i,
  input  logic [63:0]      pipe0_redirect_pc_i,

  input  logic             pipe1_valid_i,
  input  logic [4:0]       pipe1_rd_i,
  input  logic [63:0]      pipe1_value_i,
  input  logic [31:0]      pipe1_inst_i,
  input  logic [SID_W-1:0] pipe1_sid_i,
  input  logic             pipe1_redirect_i,
  input  logic [63:0]      pipe1_redirect_pc_i,

  input  logic             umul_valid_i,
  input  logic [4:0]       umul_rd_i,
  input  logic [63:0]      umul_value_i,
  input  logic [31:0]      umul_inst_i,
  input  logic [SID_W-1:0] umul_sid_i,
  output logic             umul_ready_o,

  input  logic             udiv_valid_i,
  input  logic [4:0]       udiv_rd_i,
  input  logic [63:0]      udiv_value_i,
  input  logic [31:0]      udiv_inst_i,
  input  logic [SID_W-1:0] udiv_sid_i,
  output logic             udiv_ready_o,

  input  logic             ulsu_valid_i,
  input  logic [4:0]       ulsu_rd_i,
  input  logic [63:0]      ulsu_value_i,
  input  logic [31:0]      ulsu_inst_i,
  input  logic [SID_W-1:0] ulsu_sid_i,
  output logic             ulsu_ready_o,

  output logic             wb0_valid_o,
  output logic [4:0]       wb0_rd_o,
  output logic [63:0]      wb0_value_o,
  output logic [31:0]      wb0_inst_o,
  output logic [SID_W-1:0] wb0_sid_o,
  output logic             wb0_redirect_o,
  output logic [63:0]      wb0_redirect_pc_o,

  output logic             wb1_valid_o,
  output logic [4:0]       wb1_rd_o,
  output logic [63:0]      wb1_value_o,
  output logic [31:0]      wb1_inst_o,
  output logic [SID_W-1:0] wb1_sid_o,
  output logic             wb1_redirect_o,
  output logic [63:0]      wb1_redirect_pc_o,

  output logic             stall_issue_o
);

  localparam int NU = 3;
  localparam int NP = 2;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Gather the per-source signals into arrays indexed by unit / lane number.
  logic [NU-1:0]    u_valid;
  logic [4:0]       u_rd    [NU];
  logic [63:0]      u_value [NU];
  logic [31:0]      u_inst  [NU];
  logic [SID_W-1:0] u_sid   [NU];

  assign u_valid    = {ulsu_valid_i, udiv_valid_i, umul_valid_i};
  assign u_rd[0]    = umul_rd_i;
  assign u_rd[1]    = udiv_rd_i;
  assign u_rd[2]    = ulsu_rd_i;
  assign u_value[0] = umul_value_i;
  assign u_value[1] = udiv_value_i;
  assign u_value[2] = ulsu_value_i;
  assign u_inst[0]  = umul_inst_i;
  assign u_inst[1]  = udiv_inst_i;
  assign u_inst[2]  = ulsu_inst_i;
  assign u_sid[0]   = umul_sid_i;
  assign u_sid[1]   = udiv_sid_i;
  assign u_sid[2]   = ulsu_sid_i;

  logic [NP-1:0]    p_valid;
  logic [4:0]       p_rd     [NP];
  logic [63:0]      p_value  [NP];
  logic [31:0]      p_inst   [NP];
  logic [SID_W-1:0] p_sid    [NP];
  logic [NP-1:0]    p_redirect;
  logic [63:0]      p_pc     [NP];

  assign p_valid    = {pipe1_valid_i, pipe0_valid_i};
  assign p_rd[0]    = pipe0_rd_i;
  assign p_rd[1]    = pipe1_rd_i;
  assign p_value[0] = pipe0_value_i;
  assign p_value[1] = pipe1_value_i;
  assign p_inst[0]  = pipe0_inst_i;
  assign p_inst[1]  = pipe1_inst_i;
  assign p_sid[0]   = pipe0_sid_i;
  assign p_sid[1]   = pipe1_sid_i;
  assign p_redirect = {pipe1_redirect_i, pipe0_redirect_i};
  assign p_pc[0]    = pipe0_redirect_pc_i;
  assign p_pc[1]    = pipe1_redirect_pc_i;

  // State
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q [NU];
  logic [CNT_W-1:0] cnt_d [NU];
  logic             stall_issue_q, stall_issue_d;

  // Round-robin grant: walk the units starting at rr_ptr, filling free ports
  // lowest-first. A unit that finds no free port is simply skipped.
  logic [NU-1:0]      grant;
  logic [NP-1:0]      fill;
  logic [NP-1:0][1:0] fill_unit;
  logic [1:0]         last_unit;
  logic [2:0]         sum;
  logic [1:0]         idx;

  always_comb begin
    grant     = '0;
    fill      = '0;
    fill_unit = '0;
    last_unit = rr_ptr_q;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NU; k++) begin
      sum = {1'b0, rr_ptr_q} + 3'(k);
      if (sum >= 3'd3) sum = sum - 3'd3;
      idx = sum[1:0];
      if (u_valid[idx]) begin
        if (!p_valid[0] && !fill[0]) begin
          fill[0]      = 1'b1;
          fill_unit[0] = idx;
          grant[idx]   = 1'b1;
          last_unit    = idx;
        end else if (!p_valid[1] && !fill[1]) begin
          fill[1]      = 1'b1;
          fill_unit[1] = idx;
          grant[idx]   = 1'b1;
          last_unit    = idx;
        end
      end
    end
  end

  // Pointer moves just past the last unit served this cycle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|grant) rr_ptr_d = (last_unit == 2'd2) ? 2'd0 : last_unit + 2'd1;
  end

  // Wait counters: a grant clears, an unserved request counts up and
  // saturates, no request holds. The stall looks at next-state counts so a
  // grant in the cycle the limit would be hit suppresses the stall.
  logic [NU-1:0] at_limit;

  for (genvar gi = 0; gi < NU; gi++) begin : g_cnt
    assign cnt_d[gi] = grant[gi] ? '0 :
                       (u_valid[gi] && (cnt_q[gi] != CNT_MAX)) ? cnt_q[gi] + CNT_W'(1) :
                       cnt_q[gi];
    assign at_limit[gi] = (cnt_d[gi] >= LIMIT);
  end

  assign stall_issue_d = |at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      stall_issue_q <= 1'b0;
      for (int i = 0; i < NU; i++) cnt_q[i] <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      stall_issue_q <= stall_issue_d;
      for (int i = 0; i < NU; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Writeback port mux: lane first, then the unit granted onto the port.
  logic [NP-1:0]    wb_valid;
  logic [4:0]       wb_rd    [NP];
  logic [63:0]      wb_value [NP];
  logic [31:0]      wb_inst  [NP];
  logic [SID_W-1:0] wb_sid   [NP];
  logic [NP-1:0]    wb_redirect;
  logic [63:0]      wb_pc    [NP];

  always_comb begin
    wb_valid    = '0;
    wb_redirect = '0;
    for (int p = 0; p < NP; p++) begin
      wb_rd[p]    = '0;
      wb_value[p] = '0;
      wb_inst[p]  = '0;
      wb_sid[p]   = '0;
      wb_pc[p]    = '0;
      if (p_valid[p]) begin
        wb_valid[p]    = 1'b1;
        wb_rd[p]       = p_rd[p];
        wb_value[p]    = p_value[p];
        wb_inst[p]     = p_inst[p];
        wb_sid[p]      = p_sid[p];
        wb_redirect[p] = p_redirect[p];
        wb_pc[p]       = p_pc[p];
      end else if (fill[p]) begin
        wb_valid[p] = 1'b1;
        wb_rd[p]    = u_rd[fill_unit[p]];
        wb_value[p] = u_value[fill_unit[p]];
        wb_inst[p]  = u_inst[fill_unit[p]];
        wb_sid[p]   = u_sid[fill_unit[p]];
      end
    end
  end

  // Handshake and port valids are gated by rst_n so nothing transfers while
  // reset is held, independent of the clock.
  assign umul_ready_o = grant[0] & rst_n;
  assign udiv_ready_o = grant[1] & rst_n;
  assign ulsu_ready_o = grant[2] & rst_n;

  assign wb0_valid_o       = wb_valid[0] & rst_n;
  assign wb0_rd_o          = wb_rd[0];
  assign wb0_value_o       = wb_value[0];
  assign wb0_inst_o        = wb_inst[0];
  assign wb0_sid_o         = wb_sid[0];
  assign wb0_redirect_o    = wb_redirect[0];
  assign wb0_redirect_pc_o = wb_pc[0];

  assign wb1_valid_o       = wb_valid[1] & rst_n;
  assign wb1_rd_o          = wb_rd[1];
  assign wb1_value_o       = wb_value[1];
  assign wb1_inst_o        = wb_inst[1];
  assign wb1_sid_o         = wb_sid[1];
  assign wb1_redirect_o    = wb_redirect[1];
  assign wb1_redirect_pc_o = wb_pc[1];

  assign stall_issue_o = stall_issue_q;

endmodule
